e1_buf_ram: RTL
===============

Name: e1_buf_ram

Overview:
- Buffer-side responder for one E1 unit's buffer interface: accepts RX timeslot writes and serves TX timeslot reads, keyed by (multiframe, frame, timeslot).
- Holds two byte-wide banks, RX and TX, each shared with a host port that software uses to drain RX data and fill TX data.
- Sits between one unit of the E1 wishbone core (buf_rx_*/buf_tx_* slice) and the SoC bus bridge.
- Also flags completed multiframes to the host.

Parameters:
- MFW, 7, width of the buf_*_mf multiframe counters from the E1 core.
- MBW, 2, number of multiframe LSBs used for addressing. Each bank holds 2^MBW multiframes (2^(MBW+9) bytes). Legal range 1..MFW.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- buf_rx_data  in  8  RX timeslot byte
- buf_rx_ts  in  5  RX timeslot index
- buf_rx_frame  in  4  RX frame index
- buf_rx_mf  in  MFW  RX multiframe index
- buf_rx_we  in  1  RX write strobe
- buf_rx_rdy  out  1  RX buffer ready
- buf_tx_data  out  8  TX timeslot byte
- buf_tx_ts  in  5  TX timeslot index
- buf_tx_frame  in  4  TX frame index
- buf_tx_mf  in  MFW  TX multiframe index
- buf_tx_re  in  1  TX read strobe
- buf_tx_rdy  out  1  TX buffer ready
- rx_en  in  1  host enable for RX
- tx_en  in  1  host enable for TX
- host_addr  in  MBW+10  host address; MSB 0 = RX bank, 1 = TX bank
- host_wdata  in  8  host write data
- host_we  in  1  host write (1) or read (0)
- host_req  in  1  host request, held until acked
- host_ack  out  1  one-cycle acknowledge
- host_rdata  out  8  host read data, valid with host_ack
- rx_mf_done  out  1  pulse: last byte of an RX multiframe written
- tx_mf_done  out  1  pulse: last byte of a TX multiframe read
- rx_mf_last  out  MBW  slot index of the last completed RX multiframe

Behaviour:
- Reset is asynchronous and active-low. On reset: buf_rx_rdy=0, buf_tx_rdy=0, buf_tx_data=0, host_ack=0, host_rdata=0, rx_mf_done=0, tx_mf_done=0, rx_mf_last=0, arbiter idle. RAM contents are not reset.
- Bank address = {mf[MBW-1:0], frame, ts}, 9+MBW bits. Host address uses the same layout below the bank-select MSB.
- buf_rx_rdy and buf_tx_rdy are rx_en and tx_en registered (1-cycle latency).
- RX write: buf_rx_we with buf_rx_rdy=1 writes buf_rx_data at that cycle's edge. No wait state; the E1 side always wins its bank. buf_rx_we while buf_rx_rdy=0 is ignored.
- TX read: buf_tx_re with buf_tx_rdy=1 puts the byte on buf_tx_data at the next edge. buf_tx_data holds until the next accepted read. With buf_tx_rdy=0, a read is ignored and buf_tx_data holds.
- RX and TX E1 accesses in the same cycle both complete, because the banks are independent.
- Host arbiter FSM has states IDLE, ACK.
  - IDLE -> ACK when host_req=1 and the selected bank has no E1 access in that cycle. The RAM access is performed at that edge.
  - ACK: host_ack=1 for exactly one cycle; host_rdata carries read data (unchanged on writes). Then -> IDLE.
  - A request held during the ACK cycle is not re-granted; back-to-back host accesses cost at least 2 cycles each.
  - A host access blocked by E1 traffic waits; E1 accesses are at most one per bank per cycle and are never stalled.
- rx_mf_done pulses 1 cycle after an accepted RX write with ts=31 and frame=15. The same edge loads rx_mf_last with mf[MBW-1:0].
- tx_mf_done pulses 1 cycle after an accepted TX read with ts=31 and frame=15.
- Multiframe indices wrap modulo 2^MBW; upper mf bits are ignored. Host overrun is not detected; software tracks it via rx_mf_last.
- Reset asserted mid-access aborts it: host_ack is not issued and the host must re-request. Whether the in-flight RAM write lands is undefined.

Test Plan:
- Reset, then rx_en=tx_en=1: rdy outputs are 0 during reset and 1 two edges after release. buf_tx_data=0 until the first read.
- RX write 0xA5 at mf=1, frame=3, ts=7; then host read at addr {0,01,0011,00111} -> host_ack one cycle after grant, host_rdata=0xA5.
- Host write 0x3C to TX bank mf=2, frame=0, ts=0; then buf_tx_re with mf=6 (wraps to slot 2) -> buf_tx_data=0x3C on the next cycle.
- Host read of the RX bank requested in the same cycle as buf_rx_we -> write completes, host grant delayed one cycle, host_ack one cycle later, returns the newly written byte if the addresses match.
- RX write ts=31, frame=15, mf=3 -> rx_mf_done pulses once, rx_mf_last=3. Same for TX read -> tx_mf_done pulses once.
- rx_en=0, then buf_rx_we to an address holding 0x11 -> ignored; host readback is 0x11 and rx_mf_done stays 0.

Source files
------------

// File: rtl/e1_buf_ram.sv
// e1_buf_ram: E1 buffer responder with independent RX/TX byte banks shared with a host port.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   buf_rx_data/ts/frame/mf/we  E1 RX timeslot write; buf_rx_rdy = rx_en registered
//   buf_tx_ts/frame/mf/re       E1 TX timeslot read; buf_tx_data valid the cycle after
//   buf_tx_rdy                  tx_en registered
//   rx_en, tx_en                host enables for the E1 side
//   host_addr/wdata/we/req      host access, MSB of host_addr selects TX (1) or RX (0) bank
//   host_ack, host_rdata        one-cycle acknowledge with read data
//   rx_mf_done, tx_mf_done      pulse after the last byte of a multiframe is written/read
//   rx_mf_last                  slot of the last completed RX multiframe
module e1_buf_ram #(
  parameter int MFW = 7,
  parameter int MBW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       buf_rx_data,
  input  logic [4:0]       buf_rx_ts,
  input  logic [3:0]       buf_rx_frame,
  input  logic [MFW-1:0]   buf_rx_mf,
  input  logic             buf_rx_we,
  output logic             buf_rx_rdy,
  output logic [7:0]       buf_tx_data,
  input  logic [4:0]       buf_tx_ts,
  input  logic [3:0]       buf_tx_frame,
  input  logic [MFW-1:0]   buf_tx_mf,
  input  logic             buf_tx_re,
  output logic             buf_tx_rdy,
  input  logic             rx_en,
  input  logic             tx_en,
  input  logic [MBW+9:0]   host_addr,
  input  logic [7:0]       host_wdata,
  input  logic             host_we,
  input  logic             host_req,
  output logic             host_ack,
  output logic [7:0]       host_rdata,
  output logic             rx_mf_done,
  output logic             tx_mf_done,
  output logic [MBW-1:0]   rx_mf_last
);
  localparam int AW = MBW + 9;
  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_nx;
  logic [7:0] rx_mem [2**AW];
  logic [7:0] tx_mem [2**AW];
  logic [AW-1:0] rx_a, tx_a, h_a;
  logic h_tx, rx_wr, tx_rd, grant;
  // upper multiframe bits only matter to the E1 core; slots wrap modulo 2^MBW
  logic unused;
  assign unused = ^{buf_rx_mf, buf_tx_mf};
  assign rx_a = {buf_rx_mf[MBW-1:0], buf_rx_frame, buf_rx_ts};
  assign tx_a = {buf_tx_mf[MBW-1:0], buf_tx_frame, buf_tx_ts};
  assign h_tx = host_addr[AW];
  assign h_a = host_addr[AW-1:0];
  assign rx_wr = buf_rx_we && buf_rx_rdy;
  assign tx_rd = buf_tx_re && buf_tx_rdy;
  // the E1 side always owns its bank in a cycle it touches it; the host waits
  always_comb begin
    grant = (state == IDLE) && host_req && !(h_tx ? tx_rd : rx_wr);
    state_nx = grant ? ACK : IDLE;
    host_ack = (state == ACK);
  end
  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_a] <= buf_rx_data;
    else if (grant && host_we && !h_tx) rx_mem[h_a] <= host_wdata;
    if (grant && host_we && h_tx) tx_mem[h_a] <= host_wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      buf_rx_rdy <= 1'b0;
      buf_tx_rdy <= 1'b0;
      buf_tx_data <= '0;
      host_rdata <= '0;
      rx_mf_done <= 1'b0;
      tx_mf_done <= 1'b0;
      rx_mf_last <= '0;
    end else begin
      state <= state_nx;
      buf_rx_rdy <= rx_en;
      buf_tx_rdy <= tx_en;
      if (tx_rd) buf_tx_data <= tx_mem[tx_a];
      if (grant && !host_we) host_rdata <= h_tx ? tx_mem[h_a] : rx_mem[h_a];
      rx_mf_done <= rx_wr && (&buf_rx_frame) && (&buf_rx_ts);
      tx_mf_done <= tx_rd && (&buf_tx_frame) && (&buf_tx_ts);
      if (rx_wr && (&buf_rx_frame) && (&buf_rx_ts)) rx_mf_last <= buf_rx_mf[MBW-1:0];
    end
  end
endmodule
